// File: rtl/mem_arbiter.sv
// Arbitrates the single pipelined memory port between the I-cache and D-cache fill FSMs,
// granting one whole block fill at a time and letting D-cache write-through slip into idle cycles.
module mem_arbiter #(
    parameter int MAX_GRANT = 16,
    parameter bit D_FIRST   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_busy,
    input  logic        i_read_req,
    input  logic [15:0] i_addr,
    input  logic        i_tag_wr,
    output logic        i_pause,
    output logic        i_data_valid,
    input  logic        d_busy,
    input  logic        d_read_req,
    input  logic [15:0] d_addr,
    input  logic        d_tag_wr,
    input  logic        d_wrt_mem,
    input  logic [15:0] d_wdata,
    output logic        d_pause,
    output logic        d_data_valid,
    output logic        d_wr_stall,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_enable,
    output logic        mem_wr,
    input  logic        mem_data_valid,
    output logic [1:0]  owner,
    output logic        grant_err
);

    localparam int CNT_W = ($clog2(MAX_GRANT) > 4) ? $clog2(MAX_GRANT) : 4;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_GRANT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10
    } owner_e;

    owner_e           owner_q, owner_d;
    logic             last_d_q, last_d_d;   // 1 when the D-cache held the most recent grant
    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic             grant_err_q, grant_err_d;
    logic             timeout;
    logic             i_rd, d_rd, wr_thru;

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q     <= OWN_NONE;
            last_d_q    <= ~D_FIRST;
            grant_cnt_q <= '0;
            grant_err_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            last_d_q    <= last_d_d;
            grant_cnt_q <= grant_cnt_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign timeout = (owner_q != OWN_NONE) && (grant_cnt_q == CNT_LIMIT);

    // A release hands straight to the other FSM when it is already waiting, so no idle cycle.
    always_comb begin
        owner_d     = owner_q;
        last_d_d    = last_d_q;
        grant_cnt_d = grant_cnt_q;
        grant_err_d = grant_err_q | timeout;
        case (owner_q)
            OWN_NONE: begin
                if (i_busy && d_busy) owner_d = last_d_q ? OWN_I : OWN_D;
                else if (i_busy)      owner_d = OWN_I;
                else if (d_busy)      owner_d = OWN_D;
            end
            OWN_I: if (i_tag_wr || timeout) owner_d = d_busy ? OWN_D : OWN_NONE;
            OWN_D: if (d_tag_wr || timeout) owner_d = i_busy ? OWN_I : OWN_NONE;
            default: owner_d = OWN_NONE;
        endcase
        if (owner_d != owner_q) begin
            grant_cnt_d = '0;
            if (owner_d != OWN_NONE) last_d_d = (owner_d == OWN_D);
        end else if (owner_q != OWN_NONE && grant_cnt_q != CNT_SAT) begin
            grant_cnt_d = grant_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        i_rd         = (owner_q == OWN_I) && i_read_req;
        d_rd         = (owner_q == OWN_D) && d_read_req;
        wr_thru      = d_wrt_mem && !d_busy && !i_rd && !d_rd;
        mem_addr     = i_rd ? i_addr : d_addr;
        mem_wdata    = d_wdata;
        mem_enable   = i_rd || d_rd || wr_thru;
        mem_wr       = wr_thru;
        i_pause      = i_busy && (owner_q != OWN_I);
        d_pause      = d_busy && (owner_q != OWN_D);
        d_wr_stall   = d_wrt_mem && !d_busy && (owner_q == OWN_I) && i_read_req;
        i_data_valid = mem_data_valid && (owner_q == OWN_I);
        d_data_valid = mem_data_valid && (owner_q == OWN_D);
    end

    assign owner     = owner_q;
    assign grant_err = grant_err_q;

endmodule
